outputs_workload_dispatch: RTL and testbench
============================================

// Module: outputs_workload_dispatch
// PURPOSE
//  Downstream stage of the per-output workload calculator. Captures one set of
//  per-output {id,size} descriptors per valid/ready handshake and forks them to
//  num_out_p independent output channels, each with its own valid/ready.
//  Holds the set until every channel with nonzero size has accepted its entry.
//  Zero-size entries are never sent. Counts completed workloads.
// PARAMETERS
//  id_width_p     (none)  workload id field width
//  size_width_p   (none)  workload size field width
//  num_out_p      (none)  number of output channels, >=1
//  count_width_p  16      width of the completed-workload counter
//  width_p        id_width_p+size_width_p  descriptor width: {id[MSBs], size[LSBs]}
// PORTS
//  clk_i          in   1                    clock, rising edge
//  reset_n_i      in   1                    reset, asynchronous, active-low
//  v_i            in   1                    input descriptor set valid
//  data_i         in   num_out_p*width_p    per-output descriptors, packed [num_out_p-1:0][width_p-1:0]
//  ready_o        out  1                    can accept data_i this cycle
//  v_o            out  num_out_p            per-channel descriptor valid
//  data_o         out  num_out_p*width_p    per-channel held descriptor
//  ready_i        in   num_out_p            per-channel consumer ready
//  done_count_o   out  count_width_p        workloads fully dispatched since reset
//  busy_o         out  1                    a descriptor set is held
// BEHAVIOUR
//  - Reset (reset_n_i=0, async): state=IDLE, pending mask=0, data regs=0,
//    done_count_o=0. So v_o=0, data_o=0, busy_o=0, ready_o=1.
//  - States: IDLE (nothing held), DISPATCH (pending mask nonzero).
//  - Accept: v_i & ready_o at a rising edge.
//    - Captures data_i into data regs.
//    - Pending mask is loaded with bit i = (size field of data_i[i] != 0).
//    - Nonzero mask: go to DISPATCH.
//    - All-zero mask: stay IDLE and increment done_count_o. No output goes valid.
//  - DISPATCH outputs: v_o[i] = pending[i]. data_o[i] = held descriptor i.
//    data_o stays stable while v_o[i]=1.
//  - A channel fires when v_o[i] & ready_i[i]. At the edge, pending[i] clears.
//    Channels fire independently, in any order and in any combination in one cycle.
//  - Completing cycle: the firing set equals the pending mask.
//    At that edge: done_count_o increments, and the block returns to IDLE unless a
//    new set is accepted.
//  - ready_o = (state==IDLE) | completing-cycle (combinational from ready_i).
//    This allows back-to-back sets with zero bubble. v_o never depends on v_i.
//  - Accept and completion at the same edge: the new set loads, the counter
//    increments once, and the new pending mask is used.
//    If the new set is all-zero, the counter increments twice (+2) and the block
//    goes to IDLE.
//  - ready_i[i] while v_o[i]=0 is ignored. v_i while ready_o=0 is ignored; the
//    upstream holds it.
//  - num_out_p==1: same rules with a 1-bit mask.
//  - done_count_o wraps modulo 2^count_width_p, with no saturation.
//  - Reset asserted mid-DISPATCH: all pending entries are dropped. v_o falls
//    immediately (async), and the counter clears.
//  - busy_o = (state==DISPATCH).
// TESTING
//  1. num_out_p=4, one set with sizes {5,5,5,5}, all ready_i=1 ->
//     v_o=4'hF for 1 cycle, done_count_o=1, ready_o stays 1.
//  2. Sizes {3,0,7,0} -> v_o=4'b0101 only. ready_i=4'b0001 then 4'b0100 on the
//     next cycle -> done_count_o increments once, after the second cycle.
//  3. All sizes 0 -> v_o stays 0, done_count_o+1 at the accept edge, ready_o
//     never drops.
//  4. Continuous v_i with ready_i=all-1 for 8 sets -> 8 sets in 8 cycles,
//     done_count_o=8, and data_o matches each set (id and size fields) in order.
//  5. Random per-channel ready_i stalls over 1000 sets -> every nonzero entry
//     is delivered exactly once, and data_o is stable while v_o=1 & ready_i=0.
//  6. Assert reset_n_i low mid-dispatch with v_o=4'b0110 -> v_o=0 and
//     done_count_o=0 without waiting for a clock edge. Normal operation resumes
//     after release.

Source files
------------

// File: rtl/outputs_workload_dispatch_if.sv
// Handshake bundle for the per-output workload dispatcher:
// one upstream descriptor set in, num_out_p independent channels out.
interface outputs_workload_dispatch_if #(
   parameter int id_width_p    = 8,
   parameter int size_width_p  = 8,
   parameter int num_out_p     = 4,
   parameter int count_width_p = 16,
   parameter int width_p       = id_width_p + size_width_p
);
   logic                                v_i;
   logic [num_out_p-1:0][width_p-1:0]   data_i;
   logic                                ready_o;
   logic [num_out_p-1:0]                v_o;
   logic [num_out_p-1:0][width_p-1:0]   data_o;
   logic [num_out_p-1:0]                ready_i;
   logic [count_width_p-1:0]            done_count_o;
   logic                                busy_o;

   modport slave (
      input  v_i, data_i, ready_i,
      output ready_o, v_o, data_o, done_count_o, busy_o
   );

   modport master (
      output v_i, data_i, ready_i,
      input  ready_o, v_o, data_o, done_count_o, busy_o
   );
endinterface

// File: rtl/outputs_workload_dispatch.sv
// Holds one set of per-output {id,size} descriptors and forks it to
// independent valid/ready channels; zero-size entries are skipped.
module outputs_workload_dispatch #(
   parameter int id_width_p    = 8,
   parameter int size_width_p  = 8,
   parameter int num_out_p     = 4,
   parameter int count_width_p = 16,
   parameter int width_p       = id_width_p + size_width_p
) (
   input logic                          clk_i,
   input logic                          reset_n_i,
   outputs_workload_dispatch_if.slave   bus
);

   typedef enum logic {IDLE, DISPATCH} state_e;

   state_e                              state_q, state_d;
   logic [num_out_p-1:0]                pend_q, pend_d;
   logic [num_out_p-1:0]                fire, new_mask;
   logic [num_out_p-1:0][width_p-1:0]   data_q;
   logic [count_width_p-1:0]            count_q;
   logic                                completing, ready, accept;
   logic [1:0]                          inc;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) state_q <= IDLE;
      else            state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (accept)
         state_d = (|new_mask) ? DISPATCH : IDLE;
      else if (completing)
         state_d = IDLE;
   end

   always_comb begin
      for (int i = 0; i < num_out_p; i++)
         new_mask[i] = |bus.data_i[i][size_width_p-1:0];
      fire       = pend_q & bus.ready_i;
      completing = (state_q == DISPATCH) && (fire == pend_q);
      ready      = (state_q == IDLE) || completing;
      accept     = bus.v_i && ready;
      pend_d     = accept ? new_mask : (pend_q & ~fire);
      // a completing set and an all-zero new set each count once
      inc        = {1'b0, completing}
                 + {1'b0, accept && (new_mask == '0)};
      bus.ready_o      = ready;
      bus.v_o          = (state_q == DISPATCH) ? pend_q : '0;
      bus.data_o       = data_q;
      bus.done_count_o = count_q;
      bus.busy_o       = (state_q == DISPATCH);
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         pend_q  <= '0;
         data_q  <= '0;
         count_q <= '0;
      end else begin
         pend_q  <= pend_d;
         count_q <= count_q + count_width_p'(inc);
         if (accept) data_q <= bus.data_i;
      end
   end

endmodule

// File: tb/tb_outputs_workload_dispatch.sv
// Scoreboard bench for outputs_workload_dispatch: directed cases plus
// randomized sets with random per-channel stalls.
module tb_outputs_workload_dispatch;
   localparam int ID = 4;
   localparam int SZ = 4;
   localparam int N  = 4;
   localparam int CW = 8;
   localparam int W  = ID + SZ;

   typedef logic [W-1:0]        desc_t;
   typedef logic [N-1:0][W-1:0] set_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   outputs_workload_dispatch_if #(
      .id_width_p(ID), .size_width_p(SZ), .num_out_p(N),
      .count_width_p(CW)
   ) bus ();

   outputs_workload_dispatch #(
      .id_width_p(ID), .size_width_p(SZ), .num_out_p(N),
      .count_width_p(CW)
   ) dut (
      .clk_i(clk),
      .reset_n_i(rst_n),
      .bus(bus)
   );

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   bit mon_en = 0;
   bit rand_rdy = 0;

   set_t          issued_q[$];
   logic [N-1:0]  exp_pend = '0;
   desc_t         exp_desc[N];
   logic [CW-1:0] model_count = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // scoreboard monitor: sampled on the falling edge
   always @(negedge clk) begin
      logic busy_m, rdy_m, nz;
      set_t s, e;
      if (mon_en && rst_n) begin
         chk("v_o", 64'(bus.v_o), 64'(exp_pend));
         busy_m = |exp_pend;
         rdy_m  = !busy_m || ((exp_pend & bus.ready_i) == exp_pend);
         chk("busy_o", 64'(bus.busy_o), 64'(busy_m));
         chk("ready_o", 64'(bus.ready_o), 64'(rdy_m));
         chk("done_count_o", 64'(bus.done_count_o), 64'(model_count));
         for (int i = 0; i < N; i++) begin
            if (exp_pend[i]) begin
               chk($sformatf("data_o[%0d]", i), 64'(bus.data_o[i]),
                   64'(exp_desc[i]));
            end
         end
         if (busy_m && rdy_m) model_count = model_count + 1'b1;
         exp_pend = exp_pend & ~bus.ready_i;
         if (bus.v_i && rdy_m) begin
            s = bus.data_i;
            if (issued_q.size() == 0) begin
               chk("accept_without_issue", 64'(1), 64'(0));
            end else begin
               e = issued_q.pop_front();
               chk("accepted_set", 64'(s), 64'(e));
            end
            nz = 1'b0;
            for (int i = 0; i < N; i++) begin
               if (s[i][SZ-1:0] != '0) begin
                  exp_pend[i] = 1'b1;
                  exp_desc[i] = s[i];
                  nz = 1'b1;
               end
            end
            if (!nz) model_count = model_count + 1'b1;
         end
      end
   end

   always @(posedge clk) begin
      if (rand_rdy) begin
         #1;
         bus.ready_i = N'($urandom);
      end
   end

   task automatic send_set(input set_t d);
      int n;
      bus.v_i = 1'b1;
      bus.data_i = d;
      issued_q.push_back(d);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.ready_o && n < 200);
      if (!bus.ready_o) chk("accept_timeout", 64'(0), 64'(1));
      @(posedge clk);
      #1;
      bus.v_i = 1'b0;
   endtask

   function automatic set_t mk(input int sz3, sz2, sz1, sz0, input int base);
      set_t d;
      d[3] = {ID'(base + 3), SZ'(sz3)};
      d[2] = {ID'(base + 2), SZ'(sz2)};
      d[1] = {ID'(base + 1), SZ'(sz1)};
      d[0] = {ID'(base),     SZ'(sz0)};
      return d;
   endfunction

   function automatic set_t rnd_set();
      set_t d;
      for (int i = 0; i < N; i++) begin
         d[i][W-1:SZ] = ID'($urandom_range(0, 15));
         d[i][SZ-1:0] = ($urandom_range(0, 2) == 0) ? SZ'(0)
                                                     : SZ'($urandom_range(1, 15));
      end
      return d;
   endfunction

   initial begin
      logic [CW-1:0] b;
      int c0;
      bus.v_i = 1'b0;
      bus.data_i = '0;
      bus.ready_i = '0;
      #1;
      chk("rst_v_o", 64'(bus.v_o), 64'(0));
      chk("rst_data_o", 64'(bus.data_o), 64'(0));
      chk("rst_busy_o", 64'(bus.busy_o), 64'(0));
      chk("rst_ready_o", 64'(bus.ready_o), 64'(1));
      chk("rst_count", 64'(bus.done_count_o), 64'(0));
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      mon_en = 1'b1;

      // all four channels ready at once
      bus.ready_i = '1;
      b = model_count;
      send_set(mk(5, 5, 5, 5, 0));
      chk("t1_v_o", 64'(bus.v_o), 64'hF);
      @(posedge clk);
      #1;
      chk("t1_v_o_after", 64'(bus.v_o), 64'h0);
      chk("t1_count", 64'(bus.done_count_o), 64'(CW'(b + 1)));

      // sparse set, channels fire on different cycles
      bus.ready_i = '0;
      b = model_count;
      send_set(mk(0, 7, 0, 3, 4));
      chk("t2_v_o", 64'(bus.v_o), 64'b0101);
      bus.ready_i = 4'b0001;
      @(posedge clk);
      #1;
      chk("t2_v_o_mid", 64'(bus.v_o), 64'b0100);
      chk("t2_count_mid", 64'(bus.done_count_o), 64'(b));
      bus.ready_i = 4'b0100;
      @(posedge clk);
      #1;
      chk("t2_count", 64'(bus.done_count_o), 64'(CW'(b + 1)));
      bus.ready_i = '0;

      // all-zero set counts at accept
      b = model_count;
      send_set(mk(0, 0, 0, 0, 8));
      chk("t3_v_o", 64'(bus.v_o), 64'h0);
      chk("t3_count", 64'(bus.done_count_o), 64'(CW'(b + 1)));

      // back-to-back, zero bubble
      bus.ready_i = '1;
      b = model_count;
      c0 = cyc;
      for (int k = 0; k < 8; k++) send_set(mk(k + 1, 1, 15, k + 2, k));
      chk("t4_cycles", 64'(cyc - c0), 64'(8));
      @(posedge clk);
      #1;
      chk("t4_count", 64'(bus.done_count_o), 64'(CW'(b + 8)));

      // zero set accepted at a completing edge: +2
      bus.ready_i = '1;
      b = model_count;
      send_set(mk(2, 2, 2, 2, 3));
      send_set(mk(0, 0, 0, 0, 5));
      chk("t4b_count", 64'(bus.done_count_o), 64'(CW'(b + 2)));
      chk("t4b_busy", 64'(bus.busy_o), 64'(0));

      // random sets with random stalls; counter wraps past 2^CW
      rand_rdy = 1'b1;
      for (int k = 0; k < 1000; k++) begin
         send_set(rnd_set());
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 2)) @(posedge clk);
            #1;
         end
      end
      rand_rdy = 1'b0;
      @(posedge clk);
      #2;
      bus.ready_i = '1;
      repeat (3) @(posedge clk);
      #1;
      chk("t5_drained", 64'(bus.v_o), 64'h0);
      chk("t5_issued_left", 64'(issued_q.size()), 64'(0));

      // async reset in the middle of a dispatch
      bus.ready_i = '0;
      send_set(mk(0, 6, 5, 0, 9));
      @(negedge clk);
      #2;
      chk("t6_v_o_before", 64'(bus.v_o), 64'b0110);
      mon_en = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("t6_v_o", 64'(bus.v_o), 64'h0);
      chk("t6_count", 64'(bus.done_count_o), 64'h0);
      chk("t6_busy", 64'(bus.busy_o), 64'h0);
      chk("t6_ready", 64'(bus.ready_o), 64'h1);
      exp_pend = '0;
      model_count = '0;
      issued_q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      mon_en = 1'b1;
      bus.ready_i = '1;
      send_set(mk(1, 0, 9, 4, 2));
      @(posedge clk);
      #1;
      chk("t6_resume_count", 64'(bus.done_count_o), 64'h1);
      repeat (2) @(posedge clk);
      #1;
      mon_en = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
